multicycle_cpu: RTL and testbench

Parametrised multi-cycle RV32I-subset core: the next-generation replacement for the team's single-cycle CPU top. It folds register file, ALU, sign extension, control and both memories into one FSM-sequenced datapath, so each instruction takes 3–5 cycles instead of one. Data width, memory depths and reset vector are configurable, and a load port lets the bench write programs into the core. It is the top-level CPU block, driven by one clock and producing `a0` for the display/test harness.

---
 rtl/multicycle_cpu_if.sv | 8 +
 rtl/multicycle_cpu.sv | 120 ++++++++++++
 tb/tb_multicycle_cpu.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/multicycle_cpu_if.sv
// multicycle_cpu_if: program-load port into the core's instruction memory
interface multicycle_cpu_if #(parameter int IMEM_DEPTH = 256);
  logic                          imem_we;
  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr;
  logic [31:0]                   imem_wdata;
  modport master(output imem_we, imem_addr, imem_wdata);
  modport slave(input imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: FSM-sequenced RV32I-subset core; MULTICYCLE_CPU_JAL_EN adds jal/jalr
module multicycle_cpu #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDRESS_WIDTH = 5,
  parameter int          PC_WIDTH      = 32,
  parameter int          IMEM_DEPTH    = 256,
  parameter int          DMEM_DEPTH    = 256,
  parameter int unsigned RESET_PC      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_cpu_if.slave       load,
  output logic [DATA_WIDTH-1:0] a0,
  output logic                  EQ,
  output logic [PC_WIDTH-1:0]   PC,
  output logic [2:0]            state,
  output logic                  halted,
  output logic [31:0]           retired
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} st_t;
  st_t st, nxt;
  logic [31:0] imem [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0] dmem [DMEM_DEPTH];
  logic [DATA_WIDTH-1:0] rf [2**ADDRESS_WIDTH];
  logic [31:0] ir, imm32, imm_base;
  logic [DATA_WIDTH-1:0] a, b, imm, alu_out, mdr, alu_res, op_b;
  logic [PC_WIDTH-1:0] pc, pc4, pc_nxt;
  logic [6:0] op;
  logic [2:0] f3;
  logic [ADDRESS_WIDTH-1:0] rs1, rs2, rd;
  logic alu_ok, is_r, is_i, is_lw, is_sw, is_br, is_lui, is_ecall, is_jal, is_jalr, br_taken;
  assign op       = ir[6:0];
  assign f3       = ir[14:12];
  assign rs1      = ADDRESS_WIDTH'(ir[19:15]);
  assign rs2      = ADDRESS_WIDTH'(ir[24:20]);
  assign rd       = ADDRESS_WIDTH'(ir[11:7]);
  assign alu_ok   = f3 inside {3'd0, 3'd2, 3'd6, 3'd7};
  assign is_r     = op == 7'b0110011 && alu_ok;
  assign is_i     = op == 7'b0010011 && alu_ok;
  assign is_lw    = op == 7'b0000011 && f3 == 3'd2;
  assign is_sw    = op == 7'b0100011 && f3 == 3'd2;
  assign is_br    = op == 7'b1100011 && f3[2:1] == 2'b00;
  assign is_lui   = op == 7'b0110111;
  assign is_ecall = ir == 32'h0000_0073;
  assign imm_base = is_sw  ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
                    is_br  ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
                    is_lui ? {ir[31:12], 12'b0} :
                             {{20{ir[31]}}, ir[31:20]};
`ifdef MULTICYCLE_CPU_JAL_EN
  assign is_jal  = op == 7'b1101111;
  assign is_jalr = op == 7'b1100111 && f3 == 3'd0;
  assign imm32   = is_jal ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} : imm_base;
`else
  assign is_jal  = 1'b0;
  assign is_jalr = 1'b0;
  assign imm32   = imm_base;
`endif
  assign op_b     = is_r ? b : imm;
  assign pc4      = pc + PC_WIDTH'(4);
  assign br_taken = is_br && ((a == b) ^ f3[0]);
  always_comb begin
    alu_res = is_lui ? imm :
              (is_lw | is_sw) ? a + imm :
              (is_jal | is_jalr) ? DATA_WIDTH'(pc4) :
              f3 == 3'd7 ? a & op_b :
              f3 == 3'd6 ? a | op_b :
              f3 == 3'd2 ? DATA_WIDTH'($signed(a) < $signed(op_b)) :
              (is_r && ir[30]) ? a - op_b : a + op_b;
    pc_nxt = (st == EXEC && br_taken) || (st == WB && is_jal) ? pc + PC_WIDTH'(imm) :
             (st == WB && is_jalr) ? PC_WIDTH'(a + imm) & ~PC_WIDTH'(1) : pc4;
    nxt = st == FETCH  ? DECODE :
          st == DECODE ? (is_ecall ? HALT : EXEC) :
          st == EXEC   ? ((is_lw | is_sw) ? MEM : (is_r | is_i | is_lui | is_jal | is_jalr) ? WB : FETCH) :
          st == MEM    ? (is_lw ? WB : FETCH) :
          st == WB     ? FETCH : HALT;
  end
  always_ff @(posedge clk) st <= rst ? FETCH : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= PC_WIDTH'(RESET_PC);
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      EQ      <= 1'b0;
      halted  <= 1'b0;
      retired <= '0;
      for (int i = 0; i < 2**ADDRESS_WIDTH; i++) rf[i] <= '0;
    end else begin
      if (st == FETCH) ir <= imem[pc[2 +: IW]];
      if (st == DECODE) begin
        a   <= rf[rs1];
        b   <= rf[rs2];
        imm <= DATA_WIDTH'($signed(imm32));
      end
      if (st == EXEC) alu_out <= alu_res;
      if (st == EXEC && is_br) EQ <= a == b;
      if (st == MEM) mdr <= dmem[alu_out[2 +: DW]];
      // rf[0] is cleared by reset and never written, so x0 always reads 0
      if (st == WB && rd != '0) rf[rd] <= is_lw ? mdr : alu_out;
      if (nxt == FETCH) begin
        pc      <= pc_nxt;
        retired <= retired + 32'd1;
      end
      halted <= nxt == HALT;
    end
  end
  // memories survive reset; program loading is only accepted while held in reset
  always_ff @(posedge clk) begin
    if (rst && load.imem_we) imem[load.imem_addr] <= load.imem_wdata;
    if (!rst && st == MEM && is_sw) dmem[alu_out[2 +: DW]] <= b;
  end
  assign a0    = rf[10];
  assign PC    = pc;
  assign state = st;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed programs with hand-computed register/PC/state expectations
module tb_multicycle_cpu;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] a0, pc, retired;
  logic eq, halted;
  logic [2:0] state;
  int checks = 0, passed = 0;
  logic [31:0] prog[$];
  logic [31:0] seen[$];
  logic [31:0] exp_alu[7] = '{32'hFFFF_FFF7, 32'h1, 32'h2, 32'hFFFF_FFFB, 32'hF0, 32'hFFFF_FFF3, 32'h0};
  multicycle_cpu_if #(.IMEM_DEPTH(256)) load();
  multicycle_cpu dut (.clk(clk), .rst(rst), .load(load), .a0(a0), .EQ(eq), .PC(pc), .state(state), .halted(halted), .retired(retired));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load_prog();
    rst = 1'b1;
    foreach (prog[i]) begin
      load.imem_we    = 1'b1;
      load.imem_addr  = 8'(i);
      load.imem_wdata = prog[i];
      tick(1);
    end
    load.imem_we = 1'b0;
    tick(1);
  endtask
  task automatic run_to_halt(input int max);
    logic [31:0] last;
    int c;
    last = a0;
    c = 0;
    seen.delete();
    while (!halted && c < max) begin
      tick(1);
      c++;
      if (a0 !== last) begin
        seen.push_back(a0);
        last = a0;
      end
    end
    check("halt_reached", {31'b0, halted}, 32'd1);
  endtask
  initial begin
    load.imem_we = 1'b0;
    load.imem_addr = '0;
    load.imem_wdata = '0;
    #1;
    prog = '{32'h0050_0513, 32'h0000_0073};
    load_prog();
    check("rst_a0", a0, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_state", {29'b0, state}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_eq", {31'b0, eq}, 32'd0);
    rst = 1'b0;
    tick(3);
    check("addi_a0_early", a0, 32'd0);
    tick(1);
    check("addi_a0", a0, 32'd5);
    tick(2);
    check("ecall_halted", {31'b0, halted}, 32'd1);
    check("ecall_state", {29'b0, state}, 32'd5);
    check("ecall_retired", retired, 32'd1);
    check("ecall_pc", pc, 32'd4);
    tick(3);
    check("halt_sticky", {29'b0, state}, 32'd5);
    prog = '{32'hFFA0_0093, 32'h0030_0113, 32'h4020_8533, 32'h0020_A533, 32'h0020_F533,
             32'h0020_E533, 32'h0F00_F513, 32'hFF01_6513, 32'hFFF1_2513, 32'h0000_0073};
    load_prog();
    rst = 1'b0;
    tick(8);
    for (int i = 0; i < 7; i++) begin
      tick(4);
      check($sformatf("alu_%0d", i), a0, exp_alu[i]);
    end
    tick(2);
    check("alu_retired", retired, 32'd9);
    prog = '{32'h0030_0513, 32'hFFF5_0513, 32'hFE05_1EE3, 32'h0000_0073};
    load_prog();
    rst = 1'b0;
    run_to_halt(200);
    check("loop_steps", seen.size(), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) check($sformatf("loop_a0_%0d", i), seen[i], 32'(3 - i));
    check("loop_eq", {31'b0, eq}, 32'd1);
    check("loop_retired", retired, 32'd7);
    check("loop_pc", pc, 32'd12);
    prog = '{32'h1234_52B7, 32'h0050_2423, 32'h0080_2503, 32'h0000_0073};
    load_prog();
    rst = 1'b0;
    tick(12);
    check("lw_a0_early", a0, 32'd0);
    tick(1);
    check("lw_a0", a0, 32'h1234_5000);
    prog = '{32'h0070_0013, 32'h0000_0533, 32'h0000_0073};
    load_prog();
    rst = 1'b0;
    tick(8);
    check("x0_a0", a0, 32'd0);
    check("x0_retired", retired, 32'd2);
    prog = '{32'h0050_0313, 32'h0060_2023, 32'h0000_0073};
    load_prog();
    rst = 1'b0;
    run_to_halt(50);
    prog = '{32'h0070_0313, 32'h0060_2023, 32'h0000_2503, 32'h0000_0073};
    load_prog();
    rst = 1'b0;
    tick(7);
    check("sw_in_mem", {29'b0, state}, 32'd3);
    rst = 1'b1;
    tick(1);
    check("abort_pc", pc, 32'd0);
    check("abort_state", {29'b0, state}, 32'd0);
    check("abort_retired", retired, 32'd0);
    prog = '{32'h0000_2503, 32'h0000_0073};
    load_prog();
    rst = 1'b0;
    tick(5);
    check("abort_mem_kept", a0, 32'd5);
    prog = '{32'h0080_056F, 32'h0000_0073, 32'h0000_0073, 32'h0000_0073};
    load_prog();
    rst = 1'b0;
`ifdef MULTICYCLE_CPU_JAL_EN
    tick(4);
    check("jal_a0", a0, 32'd4);
    check("jal_pc", pc, 32'd8);
    check("jal_retired", retired, 32'd1);
`else
    tick(3);
    check("jal_nop_a0", a0, 32'd0);
    check("jal_nop_pc", pc, 32'd4);
    check("jal_nop_state", {29'b0, state}, 32'd0);
    check("jal_nop_retired", retired, 32'd1);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
